// File: rtl/signed_accum_pkg.sv
// Shared types and the saturation helper for the signed frame accumulator.
// The helper works on a fixed wide word so one function serves any M up to SAT_W.
package signed_accum_pkg;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam int SAT_W = 64;

  // Returns {clamp, value}: value is raw clamped to the signed m-bit range.
  function automatic logic [SAT_W:0] saturate(input logic signed [SAT_W:0] raw,
                                               input int unsigned m);
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    logic [SAT_W:0]        res;
    one = {{SAT_W{1'b0}}, 1'b1};
    hi  = (one <<< (m - 1)) - one;
    lo  = -(one <<< (m - 1));
    if (raw > hi)
      res = {1'b1, hi[SAT_W-1:0]};
    else if (raw < lo)
      res = {1'b1, lo[SAT_W-1:0]};
    else
      res = {1'b0, raw[SAT_W-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/signext.sv
// Sign-extends an N-bit two's-complement value to M bits.
module signext #(
  parameter int N = 2,
  parameter int M = 5
) (
  input  logic [N-1:0] narrow,
  output logic [M-1:0] wide
);

  assign wide = {{(M-N){narrow[N-1]}}, narrow};

endmodule

// File: rtl/signed_accum.sv
// Frame accumulator: sums COUNT widened samples with per-step saturation and
// presents the frame sum plus a sticky overflow flag over a valid/ready handshake.
module signed_accum
  import signed_accum_pkg::*;
#(
  parameter int N     = 2,
  parameter int M     = 5,
  parameter int COUNT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_val,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [M-1:0] o_sum,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_ovf
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

  state_t                state, state_nxt;
  logic signed [M-1:0]   ext;
  logic signed [M-1:0]   acc;
  logic signed [M-1:0]   acc_nxt;
  logic signed [M:0]     raw;
  logic signed [SAT_W:0] raw_w;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  clamp;
  logic                  accept;
  logic                  last;

  signext #(.N(N), .M(M)) u_signext (
    .narrow (i_val),
    .wide   (ext)
  );

  // Step: widen, add in M+1 bits, clamp back to M bits.
  assign raw     = $signed({acc[M-1], acc}) + $signed({ext[M-1], ext});
  assign raw_w   = (SAT_W+1)'(raw);
  assign acc_nxt = M'(saturate(raw_w, M));
  assign clamp   = 1'(saturate(raw_w, M) >> SAT_W);
  assign accept  = i_valid && o_ready;
  assign last    = (cnt == CW'(COUNT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      ACC: begin
        o_ready = 1'b1;
        if (accept && last) state_nxt = HOLD;
      end
      HOLD: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      o_sum <= '0;
      o_ovf <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            ovf <= ovf | clamp;
            if (last) begin
              o_sum <= acc_nxt;
              o_ovf <= ovf | clamp;
            end
          end
        end
        HOLD: begin
          // o_sum is left alone after the handshake; o_valid qualifies it.
          if (i_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
